t09_cell_painter: RTL and testbench

//   Downstream of the frame tracker. Queues changed grid cells (x, y, obj_code on diff) in a FIFO.
//   For each queued cell, emits an ILI9341-style byte stream (CASET/PASET window, RAMWR, 20x20 RGB565 fill).
//   The stream goes to the 8080 parallel bus driver through a valid/ready byte handshake.

---
 rtl/t09_pkg.sv | 45 ++++
 rtl/t09_cell_fifo.sv | 50 +++++
 rtl/t09_cell_painter.sv | 195 +++++++++++++++++++
 tb/tb_t09_cell_painter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t09_pkg.sv
// Shared definitions for the cell painter: object codes, RGB565 colours,
// display opcodes and the painter FSM state type.
package t09_pkg;

    localparam logic [2:0] OBJ_EMPTY  = 3'd0;
    localparam logic [2:0] OBJ_HEAD   = 3'd1;
    localparam logic [2:0] OBJ_BODY   = 3'd2;
    localparam logic [2:0] OBJ_APPLE  = 3'd3;
    localparam logic [2:0] OBJ_BORDER = 3'd4;

    localparam logic [15:0] COL_EMPTY  = 16'h0000;
    localparam logic [15:0] COL_HEAD   = 16'h07E0;
    localparam logic [15:0] COL_BODY   = 16'h03E0;
    localparam logic [15:0] COL_APPLE  = 16'hF800;
    localparam logic [15:0] COL_BORDER = 16'hFFFF;
    localparam logic [15:0] COL_ERROR  = 16'hF81F;
    localparam logic [15:0] COL_GRID   = 16'h4208;

    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_PASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_CMD,
        ST_CASET_D,
        ST_PASET_CMD,
        ST_PASET_D,
        ST_RAMWR_CMD,
        ST_PIXEL
    } painter_state_t;

    // Unknown codes paint magenta so a corrupted grid is obvious on screen.
    function automatic logic [15:0] code_colour(input logic [2:0] code);
        case (code)
            OBJ_EMPTY:  code_colour = COL_EMPTY;
            OBJ_HEAD:   code_colour = COL_HEAD;
            OBJ_BODY:   code_colour = COL_BODY;
            OBJ_APPLE:  code_colour = COL_APPLE;
            OBJ_BORDER: code_colour = COL_BORDER;
            default:    code_colour = COL_ERROR;
        endcase
    endfunction

endpackage

// File: rtl/t09_cell_fifo.sv
// Synchronous FIFO of pending cell updates; the writer may push into a full
// FIFO only in the same cycle as a pop.
module t09_cell_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign level = cnt;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/t09_cell_painter.sv
// Turns queued grid-cell updates into an ILI9341 window + RAMWR byte stream.
// Optional T09_CELL_OUTLINE_EN paints a grey outline on every non-border cell.
module t09_cell_painter
    import t09_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CELL_PX = 20
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   upd_valid,
    input  logic [3:0]             upd_x,
    input  logic [3:0]             upd_y,
    input  logic [2:0]             upd_code,
    input  logic                   wr_ready,
    output logic                   wr_valid,
    output logic                   wr_dc,
    output logic [7:0]             wr_data,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam logic [8:0] PIX_LAST = 9'(CELL_PX * CELL_PX - 1);
    localparam logic [4:0] EDGE     = 5'(CELL_PX - 1);
    localparam logic [8:0] PX       = 9'(CELL_PX);

    painter_state_t state;
    logic [3:0]  cell_x;
    logic [3:0]  cell_y;
    logic [2:0]  cell_code;
    logic [1:0]  byte_idx;
    logic [8:0]  pix_cnt;
    logic        phase;
    logic [4:0]  col;
    logic [4:0]  row;
    logic [7:0]  lo_byte;

    logic        upd_ok, push, pop, full, empty, xfer;
    logic [10:0] fifo_dout;

    // wr_valid/wr_dc/wr_data are registers loaded with the next byte on each
    // transfer, so they hold steady while wr_ready is low.
    assign upd_ok = upd_valid && (upd_y < 4'd12);
    assign pop    = (state == ST_IDLE) && !empty;
    assign push   = upd_ok && (!full || pop);
    assign xfer   = wr_valid && wr_ready;
    assign busy   = (state != ST_IDLE);

    t09_cell_fifo #(.DEPTH(DEPTH), .WIDTH(11)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .din   ({upd_x, upd_y, upd_code}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    logic [8:0] w_lo, w_hi;
    logic [1:0] nxt_idx;
    logic [7:0] win_byte;

    always_comb begin
        w_lo = (state == ST_CASET_CMD || state == ST_CASET_D) ? 9'(cell_x) * PX
                                                              : 9'(cell_y) * PX;
        w_hi = w_lo + PX - 9'd1;
        nxt_idx = (state == ST_CASET_CMD || state == ST_PASET_CMD) ? 2'd0 : byte_idx + 2'd1;
        case (nxt_idx)
            2'd0:    win_byte = {7'd0, w_lo[8]};
            2'd1:    win_byte = w_lo[7:0];
            2'd2:    win_byte = {7'd0, w_hi[8]};
            default: win_byte = w_hi[7:0];
        endcase
    end

    logic [4:0]  nxt_col, nxt_row;
    logic [15:0] nxt_rgb;

    always_comb begin
        nxt_col = 5'd0;
        nxt_row = 5'd0;
        if (state == ST_PIXEL) begin
            if (col == EDGE) begin
                nxt_row = row + 5'd1;
            end else begin
                nxt_col = col + 5'd1;
                nxt_row = row;
            end
        end
        nxt_rgb = code_colour(cell_code);
`ifdef T09_CELL_OUTLINE_EN
        if (cell_code != OBJ_BORDER &&
            (nxt_col == 5'd0 || nxt_col == EDGE || nxt_row == 5'd0 || nxt_row == EDGE))
            nxt_rgb = COL_GRID;
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            cell_x    <= '0;
            cell_y    <= '0;
            cell_code <= '0;
            byte_idx  <= '0;
            pix_cnt   <= '0;
            phase     <= 1'b0;
            col       <= '0;
            row       <= '0;
            lo_byte   <= '0;
            wr_valid  <= 1'b0;
            wr_dc     <= 1'b0;
            wr_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (!empty) begin
                    {cell_x, cell_y, cell_code} <= fifo_dout;
                    state    <= ST_CASET_CMD;
                    wr_valid <= 1'b1;
                    wr_dc    <= 1'b0;
                    wr_data  <= OP_CASET;
                end
                ST_CASET_CMD: if (xfer) begin
                    state    <= ST_CASET_D;
                    byte_idx <= 2'd0;
                    wr_dc    <= 1'b1;
                    wr_data  <= win_byte;
                end
                ST_CASET_D: if (xfer) begin
                    if (byte_idx == 2'd3) begin
                        state   <= ST_PASET_CMD;
                        wr_dc   <= 1'b0;
                        wr_data <= OP_PASET;
                    end else begin
                        byte_idx <= nxt_idx;
                        wr_data  <= win_byte;
                    end
                end
                ST_PASET_CMD: if (xfer) begin
                    state    <= ST_PASET_D;
                    byte_idx <= 2'd0;
                    wr_dc    <= 1'b1;
                    wr_data  <= win_byte;
                end
                ST_PASET_D: if (xfer) begin
                    if (byte_idx == 2'd3) begin
                        state   <= ST_RAMWR_CMD;
                        wr_dc   <= 1'b0;
                        wr_data <= OP_RAMWR;
                    end else begin
                        byte_idx <= nxt_idx;
                        wr_data  <= win_byte;
                    end
                end
                ST_RAMWR_CMD: if (xfer) begin
                    state   <= ST_PIXEL;
                    pix_cnt <= 9'd0;
                    phase   <= 1'b0;
                    col     <= nxt_col;
                    row     <= nxt_row;
                    wr_dc   <= 1'b1;
                    wr_data <= nxt_rgb[15:8];
                    lo_byte <= nxt_rgb[7:0];
                end
                ST_PIXEL: if (xfer) begin
                    if (!phase) begin
                        phase   <= 1'b1;
                        wr_data <= lo_byte;
                    end else if (pix_cnt == PIX_LAST) begin
                        state    <= ST_IDLE;
                        wr_valid <= 1'b0;
                        wr_dc    <= 1'b0;
                        wr_data  <= '0;
                    end else begin
                        pix_cnt <= pix_cnt + 9'd1;
                        phase   <= 1'b0;
                        col     <= nxt_col;
                        row     <= nxt_row;
                        wr_data <= nxt_rgb[15:8];
                        lo_byte <= nxt_rgb[7:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky until reset: a real update was lost because the queue was full.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                         overflow <= 1'b0;
        else if (upd_ok && full && !pop)   overflow <= 1'b1;
    end

endmodule

// File: tb/tb_t09_cell_painter.sv
// Bench for t09_cell_painter: random cells against a byte-stream reference
// model; honours T09_CELL_OUTLINE_EN when the build defines it.
`timescale 1ns/1ps
module tb_t09_cell_painter;

    logic       clk;
    logic       nrst;
    logic       upd_valid;
    logic [3:0] upd_x;
    logic [3:0] upd_y;
    logic [2:0] upd_code;
    logic       wr_ready;
    logic       wr_valid;
    logic       wr_dc;
    logic [7:0] wr_data;
    logic       busy;
    logic       overflow;
    logic [3:0] fifo_level;

    int checks;
    int errors;
    int n_xfer;
    int ready_mode;
    logic [8:0] exp_q[$];
    logic       pend;
    logic [8:0] pend_val;

`ifdef T09_CELL_OUTLINE_EN
    localparam bit OUTLINE = 1'b1;
`else
    localparam bit OUTLINE = 1'b0;
`endif

    t09_cell_painter #(.DEPTH(8), .CELL_PX(20)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .upd_valid  (upd_valid),
        .upd_x      (upd_x),
        .upd_y      (upd_y),
        .upd_code   (upd_code),
        .wr_ready   (wr_ready),
        .wr_valid   (wr_valid),
        .wr_dc      (wr_dc),
        .wr_data    (wr_data),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Ready driver: 0 = held low, 1 = held high, 2 = random
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wr_ready = 1'b0;
                1:       wr_ready = 1'b1;
                default: wr_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Reference model
    function automatic logic [15:0] ref_colour(int code, int r, int c);
        logic [15:0] rgb;
        case (code)
            0:       rgb = 16'h0000;
            1:       rgb = 16'h07E0;
            2:       rgb = 16'h03E0;
            3:       rgb = 16'hF800;
            4:       rgb = 16'hFFFF;
            default: rgb = 16'hF81F;
        endcase
        if (OUTLINE && code != 4 && (r == 0 || r == 19 || c == 0 || c == 19))
            rgb = 16'h4208;
        return rgb;
    endfunction

    task automatic model_add(input int x, input int y, input int code);
        int x0, x1, y0, y1;
        logic [15:0] rgb;
        x0 = x * 20; x1 = x0 + 19;
        y0 = y * 20; y1 = y0 + 19;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(x0 / 256)});
        exp_q.push_back({1'b1, 8'(x0 % 256)});
        exp_q.push_back({1'b1, 8'(x1 / 256)});
        exp_q.push_back({1'b1, 8'(x1 % 256)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(y0 / 256)});
        exp_q.push_back({1'b1, 8'(y0 % 256)});
        exp_q.push_back({1'b1, 8'(y1 / 256)});
        exp_q.push_back({1'b1, 8'(y1 % 256)});
        exp_q.push_back({1'b0, 8'h2C});
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 20; c++) begin
                rgb = ref_colour(code, r, c);
                exp_q.push_back({1'b1, rgb[15:8]});
                exp_q.push_back({1'b1, rgb[7:0]});
            end
        end
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!nrst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (!wr_valid || {wr_dc, wr_data} !== pend_val) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b dc/data=%03h, required valid=1 dc/data=%03h",
                             wr_valid, {wr_dc, wr_data}, pend_val);
                end
            end
            pend = 1'b0;
            if (wr_valid && !wr_ready) begin
                pend     = 1'b1;
                pend_val = {wr_dc, wr_data};
            end
            if (wr_valid && wr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte #%0d: unexpected dc=%0b data=%02h, none required",
                             n_xfer, wr_dc, wr_data);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({wr_dc, wr_data} !== e) begin
                        errors++;
                        $display("FAIL byte #%0d: got dc=%0b data=%02h, required dc=%0b data=%02h",
                                 n_xfer, wr_dc, wr_data, e[8], e[7:0]);
                    end
                end
                n_xfer++;
            end
        end
    end

    // Driver tasks
    task automatic push_upd(input int x, input int y, input int code);
        @(posedge clk);
        #1;
        upd_valid = 1'b1;
        upd_x     = 4'(x);
        upd_y     = 4'(y);
        upd_code  = 3'(code);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        while ((exp_q.size() != 0 || busy) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s drain: %0d bytes outstanding busy=%0b, required 0 and 0",
                     name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic check_xfers(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s transfers: got %0d, required %0d", name, got, want);
        end
    endtask

    // Tests
    task automatic test_reset();
        #1;
        checks++;
        if ({wr_valid, wr_dc, wr_data, busy, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b dc=%0b data=%02h busy=%0b ovf=%0b level=%0d, required all 0",
                     wr_valid, wr_dc, wr_data, busy, overflow, fifo_level);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wr_valid, busy, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%0b busy=%0b ovf=%0b level=%0d, required all 0",
                     wr_valid, busy, overflow, fifo_level);
        end
    endtask

    task automatic test_single(input string name, input int x, input int y, input int code);
        int start;
        ready_mode = 1;
        start = n_xfer;
        model_add(x, y, code);
        push_upd(x, y, code);
        wait_drain(name, 2000);
        check_xfers(name, n_xfer - start, 811);
    endtask

    task automatic test_random_ready();
        int start;
        ready_mode = 2;
        start = n_xfer;
        for (int i = 0; i < 3; i++) begin
            int x, y, c;
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 11);
            c = $urandom_range(0, 7);
            model_add(x, y, c);
            push_upd(x, y, c);
        end
        wait_drain("random_ready", 12000);
        check_xfers("random_ready", n_xfer - start, 3 * 811);
    endtask

    task automatic test_code_sweep();
        int start;
        ready_mode = 1;
        start = n_xfer;
        for (int c = 0; c < 8; c++) begin
            int x, y;
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 11);
            model_add(x, y, c);
            push_upd(x, y, c);
        end
        wait_drain("code_sweep", 8 * 811 + 400);
        check_xfers("code_sweep", n_xfer - start, 8 * 811);
    endtask

    task automatic test_overflow();
        int x, y, c;
        ready_mode = 0;
        x = $urandom_range(0, 15); y = $urandom_range(0, 11); c = $urandom_range(0, 7);
        model_add(x, y, c);
        push_upd(x, y, c);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL first_pop: got busy=%0b level=%0d, required busy=1 level=0", busy, fifo_level);
        end
        for (int i = 0; i < 8; i++) begin
            x = $urandom_range(0, 15); y = $urandom_range(0, 11); c = $urandom_range(0, 7);
            model_add(x, y, c);
            push_upd(x, y, c);
            checks++;
            if (fifo_level !== 4'(i + 1) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: got level=%0d ovf=%0b, required level=%0d ovf=0",
                         i, fifo_level, overflow, i + 1);
            end
        end
        x = $urandom_range(0, 15); y = $urandom_range(0, 11); c = $urandom_range(0, 7);
        push_upd(x, y, c);
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_full: got level=%0d ovf=%0b, required level=8 ovf=1", fifo_level, overflow);
        end
        push_upd($urandom_range(0, 15), $urandom_range(12, 15), $urandom_range(0, 7));
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bad_row: got level=%0d ovf=%0b, required level=8 ovf=1", fifo_level, overflow);
        end
        ready_mode = 1;
        wait_drain("overflow", 9 * 811 + 400);
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL sticky_ovf: got ovf=%0b level=%0d, required ovf=1 level=0", overflow, fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        int start, budget;
        ready_mode = 1;
        start = n_xfer;
        model_add(3, 4, 2);
        push_upd(3, 4, 2);
        budget = 500;
        while (n_xfer < start + 211 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (n_xfer < start + 211) begin
            errors++;
            $display("FAIL reach_pixel100: got %0d transfers, required %0d", n_xfer - start, 211);
        end
        // Push one more so the FIFO is non-empty when reset hits
        upd_valid = 1'b1; upd_x = 4'd1; upd_y = 4'd1; upd_code = 3'd1;
        @(posedge clk);
        #3;
        upd_valid = 1'b0;
        nrst = 1'b0;
        #1;
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b busy=%0b level=%0d ovf=%0b, required all 0",
                     wr_valid, busy, fifo_level, overflow);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        test_single("restart", 7, 9, $urandom_range(0, 7));
    endtask

    initial begin
        checks = 0; errors = 0; n_xfer = 0; ready_mode = 0;
        pend = 1'b0; pend_val = '0;
        nrst = 1'b0; upd_valid = 1'b0; upd_x = '0; upd_y = '0; upd_code = '0;
        test_reset();
        test_single("apple_origin", 0, 0, 3);
        test_single("border_corner", 15, 11, 4);
        test_single("head", 5, 6, 1);
        test_random_ready();
        test_code_sweep();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
